// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register: generic ctrl/data buses, valid/ready
// handshake backed by a 2-entry skid buffer, flush, freeze and stall counter.
module elastic_pipe_reg #(
    parameter int CTRL_SIZE         = 16,
    parameter int DATA_SIZE         = 32,
    parameter int FLUSH_CLEARS_DATA = 1,
    parameter int CNT_SIZE          = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CTRL_SIZE-1:0] i_ctrl,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CTRL_SIZE-1:0] o_ctrl,
    output logic [DATA_SIZE-1:0] o_data,
    output logic [1:0]           o_occupancy,
    output logic [CNT_SIZE-1:0]  o_stall_cycles
);

    // State encoding doubles as the stored-word count driven on o_occupancy.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic                 r_main_valid;
    logic                 r_skid_valid;
    logic [CTRL_SIZE-1:0] r_main_ctrl;
    logic [DATA_SIZE-1:0] r_main_data;
    logic [CTRL_SIZE-1:0] r_skid_ctrl;
    logic [DATA_SIZE-1:0] r_skid_data;
    logic [CNT_SIZE-1:0]  r_stall_cnt;

    logic [1:0]           w_state_n;
    logic                 w_main_valid_n;
    logic                 w_skid_valid_n;
    logic [CTRL_SIZE-1:0] w_main_ctrl_n;
    logic [DATA_SIZE-1:0] w_main_data_n;
    logic [CTRL_SIZE-1:0] w_skid_ctrl_n;
    logic [DATA_SIZE-1:0] w_skid_data_n;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_stall;

    assign o_ready     = i_enable & ~r_skid_valid & ~i_reset;
    assign w_in_fire   = i_valid & o_ready;
    assign w_out_fire  = r_main_valid & i_ready & i_enable;
    assign w_stall     = r_main_valid & ~i_ready & i_enable;

    assign o_valid        = r_main_valid;
    assign o_ctrl         = r_main_ctrl;
    assign o_data         = r_main_data;
    assign o_occupancy    = r_state;
    assign o_stall_cycles = r_stall_cnt;

    // Next-state logic: flush beats freeze, freeze beats the handshake.
    always_comb begin
        w_state_n      = r_state;
        w_main_valid_n = r_main_valid;
        w_skid_valid_n = r_skid_valid;
        w_main_ctrl_n  = r_main_ctrl;
        w_main_data_n  = r_main_data;
        w_skid_ctrl_n  = r_skid_ctrl;
        w_skid_data_n  = r_skid_data;
        if (i_flush) begin
            w_state_n      = ST_EMPTY;
            w_main_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
            w_main_ctrl_n  = {CTRL_SIZE{1'b0}};
            w_skid_ctrl_n  = {CTRL_SIZE{1'b0}};
            if (FLUSH_CLEARS_DATA != 0) begin
                w_main_data_n = {DATA_SIZE{1'b0}};
                w_skid_data_n = {DATA_SIZE{1'b0}};
            end else begin
                w_main_data_n = r_main_data;
                w_skid_data_n = r_skid_data;
            end
        end else if (!i_enable) begin
            w_state_n = r_state;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_n      = ST_ONE;
                        w_main_valid_n = 1'b1;
                        w_main_ctrl_n  = i_ctrl;
                        w_main_data_n  = i_data;
                    end else begin
                        w_state_n = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_ctrl_n = i_ctrl;
                        w_main_data_n = i_data;
                    end else if (w_in_fire) begin
                        w_state_n      = ST_FULL;
                        w_skid_valid_n = 1'b1;
                        w_skid_ctrl_n  = i_ctrl;
                        w_skid_data_n  = i_data;
                    end else if (w_out_fire) begin
                        w_state_n      = ST_EMPTY;
                        w_main_valid_n = 1'b0;
                    end else begin
                        w_state_n = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_n      = ST_ONE;
                        w_main_ctrl_n  = r_skid_ctrl;
                        w_main_data_n  = r_skid_data;
                        w_skid_valid_n = 1'b0;
                        w_skid_ctrl_n  = {CTRL_SIZE{1'b0}};
                        w_skid_data_n  = {DATA_SIZE{1'b0}};
                    end else begin
                        w_state_n = ST_FULL;
                    end
                end
                default: begin
                    w_state_n      = ST_EMPTY;
                    w_main_valid_n = 1'b0;
                    w_skid_valid_n = 1'b0;
                end
            endcase
        end
    end

    // Storage registers for both entries and the state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_ctrl  <= {CTRL_SIZE{1'b0}};
            r_main_data  <= {DATA_SIZE{1'b0}};
            r_skid_ctrl  <= {CTRL_SIZE{1'b0}};
            r_skid_data  <= {DATA_SIZE{1'b0}};
        end else begin
            r_state      <= w_state_n;
            r_main_valid <= w_main_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_main_ctrl  <= w_main_ctrl_n;
            r_main_data  <= w_main_data_n;
            r_skid_ctrl  <= w_skid_ctrl_n;
            r_skid_data  <= w_skid_data_n;
        end
    end

    // Saturating back-pressure counter; only reset clears it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= {CNT_SIZE{1'b0}};
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule
